// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized ro_in rising edges over a fixed gate window.
// Optional macro RO_PRESCALE_EN inserts an ro-domain binary prescaler ahead of the synchronizer.
module ro_freq_meter #(
   parameter int GATE_CYCLES   = 1000,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 16,
   parameter int SYNC_STAGES   = 2
`ifdef RO_PRESCALE_EN
   , parameter int PRESCALE_BITS = 4
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             ro_in,
   output logic             ro_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SETTLE  = 2'd1;
   localparam logic [1:0] S_MEASURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam int GMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int GW   = $clog2(GMAX + 1);
   localparam logic [GW-1:0]    GATE_LAST   = GW'(GATE_CYCLES - 1);
   localparam logic [GW-1:0]    SETTLE_LAST = GW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACC_MAX     = {CNT_W{1'b1}};

   logic                   ro_s;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_s;
   logic [1:0]             state_q, state_d;
   logic [GW-1:0]          gate_q, gate_d;
   logic [CNT_W-1:0]       acc_q, acc_d, acc_inc_s;
   logic                   sat_q, sat_d, sat_inc_s;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   run_q, run_d;
   logic                   done_q, done_d;

`ifdef RO_PRESCALE_EN
   logic [PRESCALE_BITS-1:0] pre_q;

   // Ro-domain divider; its MSB is a slower square wave the synchronizer can follow.
   always_ff @(posedge ro_in or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PRESCALE_BITS'(1);
      end
   end

   assign ro_s = pre_q[PRESCALE_BITS-1];
`else
   assign ro_s = ro_in;
`endif

   // Synchronizer and previous-value flop, free-running in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ro_s};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_s = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Saturating accumulator increment; the flag records a dropped edge at full scale.
   always_comb begin
      acc_inc_s = acc_q;
      sat_inc_s = sat_q;
      if (edge_s) begin
         if (acc_q == ACC_MAX) begin
            sat_inc_s = 1'b1;
         end else begin
            acc_inc_s = acc_q + CNT_W'(1);
         end
      end else begin
         acc_inc_s = acc_q;
      end
   end

   // Next-state logic; abort out-prioritizes every transition out of SETTLE/MEASURE.
   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_SETTLE;
               gate_d  = '0;
               acc_d   = '0;
               sat_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (gate_q == SETTLE_LAST) begin
               state_d = S_MEASURE;
               gate_d  = '0;
            end else begin
               gate_d  = gate_q + GW'(1);
            end
         end
         S_MEASURE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               acc_d = acc_inc_s;
               sat_d = sat_inc_s;
               if (gate_q == GATE_LAST) begin
                  state_d = S_DONE;
                  count_d = acc_inc_s;
                  ovf_d   = sat_inc_s;
               end else begin
                  gate_d  = gate_q + GW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      run_d  = (state_d == S_SETTLE) || (state_d == S_MEASURE);
      done_d = (state_d == S_DONE);
   end

   // Control state, measurement datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gate_q  <= '0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         run_q   <= run_d;
         done_q  <= done_d;
      end
   end

   assign ro_en = run_q;
   assign busy  = run_q;
   assign done  = done_q;
   assign count = count_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-bit and a 4-bit (saturating) instance share all stimulus.
module tb_ro_freq_meter;

   localparam int S     = 4;
   localparam int CLK_P = 20;
`ifdef RO_PRESCALE_EN
   localparam int G       = 320;
   localparam int RO_HALF = 5;
   localparam int PS      = 4;
`else
   localparam int G       = 100;
   localparam int RO_HALF = 40;
   localparam int PS      = 0;
`endif

   logic        clk, rst_n, start, abort, ro_in, ro_run;
   logic        ro_en16, busy16, done16, ovf16;
   logic        ro_en4, busy4, done4, ovf4;
   logic [15:0] count16;
   logic [3:0]  count4;

   int n_assert = 0;
   int n_fail   = 0;
   int sb_q[$];
   int lat;
   bit busy_ok;

   ro_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ro_in(ro_in),
      .ro_en(ro_en16), .busy(busy16), .done(done16), .count(count16), .ovf(ovf16));

   ro_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4), .SYNC_STAGES(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ro_in(ro_in),
      .ro_en(ro_en4), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4));

   initial begin
      clk = 1'b0;
      forever #(CLK_P / 2) clk = ~clk;
   end

   // Oscillator model: free-running square wave while ro_run, otherwise held low.
   initial begin
      ro_in = 1'b0;
      forever begin
         if (ro_run) begin
            #(RO_HALF) ro_in = ~ro_in;
         end else begin
            ro_in = 1'b0;
            #7;
         end
      end
   end

   function automatic int nominal();
      return ro_run ? (((G * CLK_P) / (2 * RO_HALF)) >> PS) : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input int obs, input logic ovf_obs, input int nom, input int maxv);
      int tol;
      if (nom > maxv) begin
         chk({tag, "_sat"}, obs, maxv);
         chk({tag, "_ovf"}, ovf_obs, 1);
      end else begin
         tol = (nom == 0) ? 0 : 1;
         n_assert++;
         assert ((obs + tol >= nom) && (obs <= nom + tol)) else begin
            n_fail++;
            $error("FAIL %s_cnt: observed %0d expected %0d +/- %0d", tag, obs, nom, tol);
         end
         chk({tag, "_ovf"}, ovf_obs, 0);
      end
   endtask

   // Called on the negedge after the start edge (c=0). Returns on the negedge where done is seen.
   task automatic wait_done(input int budget, input int p1, input int p2, input int ab,
                            output int lat_o, output bit ok_o);
      int nom;
      lat_o = -1;
      ok_o  = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (done16) begin
            lat_o = c;
            chk("done4_sync", done4, 1);
            chk("busy4_at_done", busy4, 0);
            chk("roen4_at_done", ro_en4, 0);
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               nom = sb_q.pop_front();
               chk_cnt("w16", count16, ovf16, nom, 65535);
               chk_cnt("w4", count4, ovf4, nom, 15);
            end
            break;
         end
         if (!busy16 || !ro_en16) ok_o = 1'b0;
         if (ab >= 0 && c == ab + 1) begin
            chk("abort_busy", busy16, 0);
            chk("abort_roen", ro_en16, 0);
         end
         start = (c == p1) || (c == p2);
         abort = (c == ab);
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      start = 1'b0; abort = 1'b0; rst_n = 1'b0; ro_run = 1'b0;
      #5;
      chk("rst_roen", ro_en16, 0); chk("rst_busy", busy16, 0); chk("rst_done", done16, 0);
      chk("rst_count", count16, 0); chk("rst_ovf", ovf16, 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1; @(negedge clk);

      // Basic run: latency, busy window, one-cycle done, result.
      ro_run = 1'b1; repeat (3) @(negedge clk);
      start = 1'b1; sb_q.push_back(nominal()); @(negedge clk);
      chk("t1_busy_start", busy16, 1); chk("t1_roen_start", ro_en16, 1);
      wait_done(S + G + 20, -1, -1, -1, lat, busy_ok);
      chk("t1_latency", lat, S + G); chk("t1_busy_window", busy_ok, 1);
      chk("t1_done_busy", busy16, 0); chk("t1_done_roen", ro_en16, 0);
      @(negedge clk);
      chk("t1_done_pulse", done16, 0); chk("t1_idle_roen", ro_en16, 0);

      // Static oscillator: zero result, no overflow on either width.
      ro_run = 1'b0; repeat (5) @(negedge clk);
      start = 1'b1; sb_q.push_back(nominal()); @(negedge clk);
      wait_done(S + G + 20, -1, -1, -1, lat, busy_ok);
      chk("t2_latency", lat, S + G);

      // start re-pulsed in SETTLE and MEASURE, then during DONE, then in the following IDLE.
      ro_run = 1'b1; repeat (3) @(negedge clk);
      start = 1'b1; sb_q.push_back(nominal()); @(negedge clk);
      wait_done(S + G + 20, 2, S + 40, -1, lat, busy_ok);
      chk("t4_latency", lat, S + G); chk("t4_busy_window", busy_ok, 1);
      start = 1'b1; @(negedge clk);
      chk("t4_done_start_ign", busy16, 0); chk("t4_single_done", done16, 0);
      sb_q.push_back(nominal()); @(negedge clk);
      chk("t4_relaunch", busy16, 1);
      wait_done(S + G + 20, -1, -1, -1, lat, busy_ok);
      chk("t4_relaunch_latency", lat, S + G);

      // Abort in MEASURE: no done, previous result held.
      start = 1'b1; @(negedge clk);
      wait_done(S + G + 20, -1, -1, S + 50, lat, busy_ok);
      chk("t3_no_done", (lat < 0), 1);
      chk_cnt("t3_hold16", count16, ovf16, nominal(), 65535);
      chk_cnt("t3_hold4", count4, ovf4, nominal(), 15);

      // abort together with start in IDLE: stay idle.
      start = 1'b1; abort = 1'b1; @(negedge clk);
      chk("abort_start_idle", busy16, 0);
      start = 1'b0; abort = 1'b0; @(negedge clk);

      // Asynchronous reset mid-MEASURE, then a fresh measurement.
      start = 1'b1; @(negedge clk);
      wait_done(S + 30, -1, -1, -1, lat, busy_ok);
      #7 rst_n = 1'b0;
      #1;
      chk("t5_roen", ro_en16, 0); chk("t5_busy", busy16, 0); chk("t5_done", done16, 0);
      chk("t5_count", count16, 0); chk("t5_ovf", ovf16, 0);
      #15 rst_n = 1'b1;
      @(negedge clk);
      chk("t5_post_busy", busy16, 0); chk("t5_post_count", count16, 0);
      start = 1'b1; sb_q.push_back(nominal()); @(negedge clk);
      wait_done(S + G + 20, -1, -1, -1, lat, busy_ok);
      chk("t5_latency", lat, S + G);
      chk("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
